// File: rtl/mem_stage_if.sv
// EX->MEM inputs and MEM->WB outputs of the memory stage, bundled as one bus.
// The master drives the EX-side fields; the slave (mem_stage) drives the WB side.
interface mem_stage_if;
  logic        stall;
  logic        flush;
  logic [3:0]  MemOp;
  logic [31:0] ALUOut;
  logic [31:0] DMWriteData_EX_to_Mem;
  logic [4:0]  RegWriteAddr_EX_to_Mem;
  logic [59:0] InstrType_EX_to_Mem;
  logic [31:0] PC_EX_to_Mem;

  logic [4:0]  RegWriteAddr_Mem_to_WB;
  logic [59:0] InstrType_Mem_to_WB;
  logic [31:0] ALUOut_Mem_to_WB;
  logic [31:0] MemReadData_Mem_to_WB;
  logic [31:0] PC_Mem_to_WB;
  logic        AddrExc_Mem_to_WB;

  modport master (
    output stall, flush, MemOp, ALUOut, DMWriteData_EX_to_Mem, RegWriteAddr_EX_to_Mem,
           InstrType_EX_to_Mem, PC_EX_to_Mem,
    input  RegWriteAddr_Mem_to_WB, InstrType_Mem_to_WB, ALUOut_Mem_to_WB,
           MemReadData_Mem_to_WB, PC_Mem_to_WB, AddrExc_Mem_to_WB
  );

  modport slave (
    input  stall, flush, MemOp, ALUOut, DMWriteData_EX_to_Mem, RegWriteAddr_EX_to_Mem,
           InstrType_EX_to_Mem, PC_EX_to_Mem,
    output RegWriteAddr_Mem_to_WB, InstrType_Mem_to_WB, ALUOut_Mem_to_WB,
           MemReadData_Mem_to_WB, PC_Mem_to_WB, AddrExc_Mem_to_WB
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: word-addressed data memory with byte/halfword access,
// alignment checking, and the MEM/WB pipeline register.
module mem_stage #(
  parameter int unsigned DM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus_io
);

  localparam int unsigned AW = $clog2(DM_WORDS);

  localparam logic [3:0] OpLw  = 4'd1;
  localparam logic [3:0] OpLh  = 4'd2;
  localparam logic [3:0] OpLhu = 4'd3;
  localparam logic [3:0] OpLb  = 4'd4;
  localparam logic [3:0] OpLbu = 4'd5;
  localparam logic [3:0] OpSw  = 4'd6;
  localparam logic [3:0] OpSh  = 4'd7;
  localparam logic [3:0] OpSb  = 4'd8;

  logic [31:0]   dm_q [DM_WORDS];
  logic [AW-1:0] word_idx;
  logic [1:0]    byte_off;
  logic [31:0]   rd_word;
  logic          is_load, is_store, misalign, store_en;
  logic [3:0]    byte_en;
  logic [31:0]   wr_lanes, wr_word;
  logic [15:0]   ld_half;
  logic [7:0]    ld_byte;
  logic [31:0]   ld_data;
  logic          unused_addr_hi;

  // Upper address bits beyond the array simply wrap.
  assign word_idx       = bus_io.ALUOut[AW+1:2];
  assign byte_off       = bus_io.ALUOut[1:0];
  assign unused_addr_hi = ^bus_io.ALUOut[31:AW+2];
  assign rd_word        = dm_q[word_idx];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    misalign = 1'b0;
    byte_en  = 4'b0000;
    wr_lanes = '0;
    case (bus_io.MemOp)
      OpLw: begin
        is_load  = 1'b1;
        misalign = |byte_off;
      end
      OpLh, OpLhu: begin
        is_load  = 1'b1;
        misalign = byte_off[0];
      end
      OpLb, OpLbu: is_load = 1'b1;
      OpSw: begin
        is_store = 1'b1;
        misalign = |byte_off;
        byte_en  = 4'b1111;
        wr_lanes = bus_io.DMWriteData_EX_to_Mem;
      end
      OpSh: begin
        is_store = 1'b1;
        misalign = byte_off[0];
        byte_en  = byte_off[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{bus_io.DMWriteData_EX_to_Mem[15:0]}};
      end
      OpSb: begin
        is_store = 1'b1;
        byte_en  = 4'b0001 << byte_off;
        wr_lanes = {4{bus_io.DMWriteData_EX_to_Mem[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      wr_word[8*b +: 8] = byte_en[b] ? wr_lanes[8*b +: 8] : rd_word[8*b +: 8];
    end
  end

  assign store_en = is_store & ~misalign & ~bus_io.stall & ~bus_io.flush;

  always_comb begin
    ld_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    ld_byte = rd_word[{byte_off, 3'b000} +: 8];
    ld_data = '0;
    if (is_load && !misalign) begin
      case (bus_io.MemOp)
        OpLw:    ld_data = rd_word;
        OpLh:    ld_data = {{16{ld_half[15]}}, ld_half};
        OpLhu:   ld_data = {16'h0000, ld_half};
        OpLb:    ld_data = {{24{ld_byte[7]}}, ld_byte};
        OpLbu:   ld_data = {24'h000000, ld_byte};
        default: ld_data = '0;
      endcase
    end
  end

  // Data memory clears on reset so no stale or in-flight store survives it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DM_WORDS; i++) begin
        dm_q[i] <= '0;
      end
    end else if (store_en) begin
      dm_q[word_idx] <= wr_word;
    end
  end

  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [59:0] itype_q, itype_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] pc_q, pc_d;
  logic        exc_q, exc_d;

  always_comb begin
    rd_addr_d = rd_addr_q;
    itype_d   = itype_q;
    alu_d     = alu_q;
    rdata_d   = rdata_q;
    pc_d      = pc_q;
    exc_d     = exc_q;
    if (bus_io.flush) begin
      rd_addr_d = '0;
      itype_d   = '0;
      alu_d     = '0;
      rdata_d   = '0;
      pc_d      = '0;
      exc_d     = 1'b0;
    end else if (!bus_io.stall) begin
      rd_addr_d = misalign ? 5'd0 : bus_io.RegWriteAddr_EX_to_Mem;
      itype_d   = bus_io.InstrType_EX_to_Mem;
      alu_d     = bus_io.ALUOut;
      rdata_d   = ld_data;
      pc_d      = bus_io.PC_EX_to_Mem;
      exc_d     = misalign;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr_q <= '0;
      itype_q   <= '0;
      alu_q     <= '0;
      rdata_q   <= '0;
      pc_q      <= '0;
      exc_q     <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr_d;
      itype_q   <= itype_d;
      alu_q     <= alu_d;
      rdata_q   <= rdata_d;
      pc_q      <= pc_d;
      exc_q     <= exc_d;
    end
  end

  assign bus_io.RegWriteAddr_Mem_to_WB = rd_addr_q;
  assign bus_io.InstrType_Mem_to_WB    = itype_q;
  assign bus_io.ALUOut_Mem_to_WB       = alu_q;
  assign bus_io.MemReadData_Mem_to_WB  = rdata_q;
  assign bus_io.PC_Mem_to_WB           = pc_q;
  assign bus_io.AddrExc_Mem_to_WB      = exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver queues the expected MEM/WB contents
// for each issued vector, and a monitor compares them one edge later.
module tb_mem_stage;

  localparam logic [3:0] OpNone = 4'd0;
  localparam logic [3:0] OpLw   = 4'd1;
  localparam logic [3:0] OpLh   = 4'd2;
  localparam logic [3:0] OpLhu  = 4'd3;
  localparam logic [3:0] OpLb   = 4'd4;
  localparam logic [3:0] OpLbu  = 4'd5;
  localparam logic [3:0] OpSw   = 4'd6;
  localparam logic [3:0] OpSh   = 4'd7;
  localparam logic [3:0] OpSb   = 4'd8;

  typedef struct packed {
    logic [4:0]  rd;
    logic [59:0] it;
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [31:0] pc;
    logic        exc;
  } wb_t;

  logic clk;
  logic reset;
  mem_stage_if bus ();

  mem_stage #(.DM_WORDS(1024)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_t exp_q[$];
  int  id_q[$];
  wb_t last_exp;
  int  vec_n = 0;
  int  pc_ctr = 0;
  int  n_checks = 0;
  int  n_pass = 0;

  task automatic chk(input string nm, input int id, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec%0d: got %h expected %h", nm, id, act, exp);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_rd"},   -1, 64'(bus.RegWriteAddr_Mem_to_WB), 64'd0);
    chk({nm, "_it"},   -1, 64'(bus.InstrType_Mem_to_WB),    64'd0);
    chk({nm, "_alu"},  -1, 64'(bus.ALUOut_Mem_to_WB),       64'd0);
    chk({nm, "_rdat"}, -1, 64'(bus.MemReadData_Mem_to_WB),  64'd0);
    chk({nm, "_pc"},   -1, 64'(bus.PC_Mem_to_WB),           64'd0);
    chk({nm, "_exc"},  -1, 64'(bus.AddrExc_Mem_to_WB),      64'd0);
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input logic st, input logic fl);
    bus.MemOp                  = op;
    bus.ALUOut                 = addr;
    bus.DMWriteData_EX_to_Mem  = wd;
    bus.RegWriteAddr_EX_to_Mem = rd;
    bus.InstrType_EX_to_Mem    = {28'hA5A5A5A, addr};
    bus.PC_EX_to_Mem           = 32'h0040_0000 + 32'(pc_ctr * 4);
    bus.stall                  = st;
    bus.flush                  = fl;
  endtask

  // erd/eexc are hand-computed load data and misalign flag for this vector.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input logic st, input logic fl,
                       input logic [31:0] erd, input logic eexc);
    wb_t e;
    @(negedge clk);
    drive(op, addr, wd, rd, st, fl);
    if (fl) e = '0;
    else if (st) e = last_exp;
    else begin
      e.rd   = eexc ? 5'd0 : rd;
      e.it   = {28'hA5A5A5A, addr};
      e.alu  = addr;
      e.rdat = erd;
      e.pc   = 32'h0040_0000 + 32'(pc_ctr * 4);
      e.exc  = eexc;
    end
    last_exp = e;
    exp_q.push_back(e);
    id_q.push_back(vec_n);
    vec_n++;
    pc_ctr++;
  endtask

  always @(posedge clk) begin
    wb_t e;
    int  id;
    #1;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      chk("rd",   id, 64'(bus.RegWriteAddr_Mem_to_WB), 64'(e.rd));
      chk("it",   id, 64'(bus.InstrType_Mem_to_WB),    64'(e.it));
      chk("alu",  id, 64'(bus.ALUOut_Mem_to_WB),       64'(e.alu));
      chk("rdat", id, 64'(bus.MemReadData_Mem_to_WB),  64'(e.rdat));
      chk("pc",   id, 64'(bus.PC_Mem_to_WB),           64'(e.pc));
      chk("exc",  id, 64'(bus.AddrExc_Mem_to_WB),      64'(e.exc));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    last_exp = '0;
    reset = 1'b0;
    drive(OpNone, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    #1;
    chk_outputs_zero("reset0");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    issue(OpLw,  32'h10, 32'h0,        5'd1, 0, 0, 32'h0000_0000, 0);
    issue(OpSw,  32'h10, 32'h12345678, 5'd0, 0, 0, 32'h0,         0);
    issue(OpLw,  32'h10, 32'h0,        5'd5, 0, 0, 32'h1234_5678, 0);
    issue(OpSb,  32'h13, 32'hFFFF_FF80, 5'd0, 0, 0, 32'h0,        0);
    issue(OpLb,  32'h13, 32'h0,        5'd6, 0, 0, 32'hFFFF_FF80, 0);
    issue(OpLbu, 32'h13, 32'h0,        5'd7, 0, 0, 32'h0000_0080, 0);
    issue(OpLw,  32'h10, 32'h0,        5'd8, 0, 0, 32'h8034_5678, 0);
    issue(OpSh,  32'h22, 32'h1234_BEEF, 5'd0, 0, 0, 32'h0,        0);
    issue(OpLh,  32'h22, 32'h0,        5'd9, 0, 0, 32'hFFFF_BEEF, 0);
    issue(OpLhu, 32'h20, 32'h0,        5'd10, 0, 0, 32'h0000_0000, 0);
    issue(OpLw,  32'h20, 32'h0,        5'd11, 0, 0, 32'hBEEF_0000, 0);
    issue(OpLb,  32'h22, 32'h0,        5'd12, 0, 0, 32'hFFFF_FFEF, 0);
    issue(OpLbu, 32'h23, 32'h0,        5'd13, 0, 0, 32'h0000_00BE, 0);
    issue(OpLw,  32'h11, 32'h0,        5'd7, 0, 0, 32'h0,          1);
    issue(OpSw,  32'h12, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'h0,         1);
    issue(OpLh,  32'h13, 32'h0,        5'd14, 0, 0, 32'h0,         1);
    issue(OpSh,  32'h21, 32'h0000_5555, 5'd0, 0, 0, 32'h0,         1);
    issue(OpLhu, 32'h21, 32'h0,        5'd15, 0, 0, 32'h0,         1);
    issue(OpLw,  32'h10, 32'h0,        5'd16, 0, 0, 32'h8034_5678, 0);
    issue(OpLw,  32'h20, 32'h0,        5'd17, 0, 0, 32'hBEEF_0000, 0);
    issue(OpSw,  32'h1040, 32'hCAFE_F00D, 5'd0, 0, 0, 32'h0,       0);
    issue(OpLw,  32'h40, 32'h0,        5'd18, 0, 0, 32'hCAFE_F00D, 0);
    issue(4'd9,  32'h40, 32'h0,        5'd19, 0, 0, 32'h0,         0);
    issue(4'd15, 32'h41, 32'h0,        5'd20, 0, 0, 32'h0,         0);
    issue(OpSw,  32'h30, 32'hAAAA_5555, 5'd21, 1, 0, 32'h0,        0);
    issue(OpLw,  32'h30, 32'h0,        5'd22, 0, 0, 32'h0000_0000, 0);
    issue(OpLw,  32'h10, 32'h0,        5'd23, 1, 1, 32'h0,         0);
    issue(OpSw,  32'h34, 32'h1111_2222, 5'd0, 0, 1, 32'h0,         0);
    issue(OpLw,  32'h34, 32'h0,        5'd24, 0, 0, 32'h0000_0000, 0);
    issue(OpLw,  32'h10, 32'h0,        5'd25, 0, 0, 32'h8034_5678, 0);

    // Reset mid-cycle while a store is presented; no clock edge before the check.
    @(negedge clk);
    drive(OpSw, 32'h10, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_outputs_zero("async_rst");
    repeat (2) @(negedge clk);
    drive(OpNone, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    reset = 1'b1;
    last_exp = '0;

    issue(OpLw,  32'h10, 32'h0,        5'd26, 0, 0, 32'h0000_0000, 0);
    issue(OpLw,  32'h40, 32'h0,        5'd27, 0, 0, 32'h0000_0000, 0);
    issue(OpNone, 32'h0, 32'h0,        5'd0, 0, 0, 32'h0,          0);

    @(posedge clk);
    #2;
    chk("drain", -1, 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DM_WORDS, default 1024, data-memory depth in 32-bit words; word index = ALUOut[log2(DM_WORDS)+1:2].
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  hold the MEM/WB register and suppress any store this cycle.
REQ-005 flush  input  1  load a bubble into the MEM/WB register and suppress any store this cycle.
REQ-006 MemOp  input  4  0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb; 9-15 treated as none.
REQ-007 ALUOut  input  32  EX-stage result, used as byte address for loads/stores.
REQ-008 DMWriteData_EX_to_Mem  input  32  store data, right-aligned.
REQ-009 RegWriteAddr_EX_to_Mem  input  5  GPR write-back address.
REQ-010 InstrType_EX_to_Mem  input  60  instruction-type vector, passed through untouched.
REQ-011 PC_EX_to_Mem  input  32  instruction PC, passed through.
REQ-012 RegWriteAddr_Mem_to_WB  output  5  registered write-back address.
REQ-013 InstrType_Mem_to_WB  output  60  registered instruction-type vector.
REQ-014 ALUOut_Mem_to_WB  output  32  registered ALU result.
REQ-015 MemReadData_Mem_to_WB  output  32  registered, extended load data; 0 for non-loads.
REQ-016 PC_Mem_to_WB  output  32  registered PC.
REQ-017 AddrExc_Mem_to_WB  output  1  registered misaligned-access flag.

Function
REQ-018 The DM SHALL be a DM_WORDS x 32 array, written only on a rising clk edge.
REQ-019 The DM SHALL be read combinationally, so a load in the cycle after a store to the same word returns the new data.
REQ-020 Alignment rules: lw/sw need ALUOut[1:0]=00; lh/lhu/sh need ALUOut[0]=0; byte ops never misalign.
REQ-021 A misaligned access SHALL write no DM bytes, set AddrExc, force MemReadData to 0 and RegWriteAddr to 0.
REQ-022 sw SHALL write all four bytes; sh writes bytes {1,0} when ALUOut[1]=0 else {3,2} with DMWriteData[15:0]; sb writes byte ALUOut[1:0] with DMWriteData[7:0]; other bytes unchanged.
REQ-023 Loads SHALL select the addressed byte/halfword; lb/lh sign-extend, lbu/lhu zero-extend, lw returns the whole word.
REQ-024 An address beyond DM_WORDS SHALL wrap modulo DM_WORDS, with no exception.
REQ-025 Latency: inputs captured at edge N appear on the *_Mem_to_WB outputs after edge N; one-cycle pipeline register.
REQ-026 With flush=1, all MEM/WB outputs SHALL load 0 at the edge and no store occurs; flush has priority over stall.
REQ-027 With stall=1 and flush=0, all MEM/WB outputs SHALL hold their values and no store occurs.
REQ-028 ALUOut_Mem_to_WB, PC_Mem_to_WB and InstrType_Mem_to_WB SHALL pass through unmodified, exceptions included.

Reset
REQ-029 While reset=0, all outputs SHALL be 0 immediately, independent of clk.
REQ-030 While reset=0, all DM words SHALL be 0 and no store takes effect.
REQ-031 A store in flight when reset asserts SHALL be discarded.
REQ-032 Normal operation SHALL resume at the first rising edge after reset deasserts.

Verification
REQ-033 Scenario: sw 0x12345678 @0x10, then lw @0x10 next cycle -> MemReadData_Mem_to_WB=0x12345678 one cycle after the lw.
REQ-034 Scenario: sb 0x80 @0x13, then lb @0x13 and lbu @0x13 -> 0xFFFFFF80 and 0x00000080; word @0x10 reads 0x80345678.
REQ-035 Scenario: sh 0xBEEF @0x22, then lh @0x22 -> 0xFFFFBEEF; lhu @0x20 -> 0x00000000.
REQ-036 Scenario: lw @0x11 -> AddrExc=1, MemReadData=0, RegWriteAddr=0, ALUOut_Mem_to_WB=0x11; sw @0x12 leaves DM unchanged.
REQ-037 Scenario: stall=1 alongside sw @0x30 -> outputs hold and word @0x30 stays 0; flush=1 with stall=1 -> outputs 0 next edge.
REQ-038 Scenario: reset=0 asserted mid-cycle after stores -> outputs 0 without a clock edge; after release, lw @0x10 returns 0.
